atmega_io_initiator: RTL and testbench
======================================

Name: atmega_io_initiator

Overview:
- Command-driven initiator for the ATmega-style I/O register bus (addr/wr/rd/data-in/data-out) used by the PIO and other IO peripherals.
- Turns single read, write, bit-set and bit-clear commands into correctly timed bus cycles and returns one response per command.
- Sits between a debug/host bridge or sequencer and any IO peripheral. It is the bus-master end of the peripheral register interface.

Parameters:
- BUS_ADDR_DATA_LEN, 8, width of bus_addr and cmd_addr.
- DATA_WIDTH, 8, width of data paths; must match the target peripheral port width.
- RD_WAIT, 0, extra cycles bus_rd is held before bus_rdata is sampled (0..15).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 read, 01 write, 10 set bits (OR), 11 clear bits (AND-NOT).
- cmd_addr  in  BUS_ADDR_DATA_LEN  target register address.
- cmd_data  in  DATA_WIDTH  write data, or bit mask for set/clear.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DATA_WIDTH  read value (read) or value written (write/set/clear).
- busy  out  1  state != IDLE.
- bus_addr  out  BUS_ADDR_DATA_LEN  address to peripherals.
- bus_wr  out  1  write strobe.
- bus_rd  out  1  read strobe.
- bus_wdata  out  DATA_WIDTH  drives peripheral data input.
- bus_rdata  in  DATA_WIDTH  peripheral data output; combinational from rd/addr.

Behaviour:
- Reset (rst low, async): state IDLE; bus_addr, bus_wr, bus_rd, bus_wdata, rsp_valid, rsp_data all 0; cmd_ready=1 once rst high. Reset mid-operation aborts immediately with no partial write completed after reset assertion; the pending response is dropped.
- States: IDLE, READ, WRITE, RESP.
- IDLE: on cmd_valid & cmd_ready (edge E0), latch op/addr/data.
  - op 01 -> WRITE.
  - All other ops -> READ.
- READ: bus_rd=1 and bus_addr=latched addr for 1+RD_WAIT cycles, counted by a 4-bit wait counter. On the last cycle's edge, capture bus_rdata.
  - op 00 -> RESP with rsp_data=captured value.
  - op 10 -> WRITE with wdata = captured | mask.
  - op 11 -> WRITE with wdata = captured & ~mask.
- WRITE: exactly one cycle with bus_wr=1, bus_addr and bus_wdata valid; the peripheral captures at the end of that cycle. Next state RESP with rsp_data=bus_wdata.
- RESP: rsp_valid=1, rsp_data stable, until rsp_valid & rsp_ready; then IDLE.
- Latency from accept edge E0 to rsp_valid:
  - read: 2+RD_WAIT edges.
  - write: 2 edges.
  - set/clear: 3+RD_WAIT edges.
- Minimum command-to-command spacing is 3 cycles.
- bus_wr and bus_rd are never high together. Outside READ/WRITE, bus_addr, bus_wdata, bus_wr and bus_rd are all 0, so no stray address decode occurs. All bus outputs are registered.
- cmd_valid while busy is ignored (cmd_ready=0). No command is accepted in the RESP cycle.
- rsp_ready held high: RESP lasts exactly one cycle.
- Set/clear with mask 0 still performs the read and a write-back of the unchanged value.
- Address and data are not range-checked. An unmapped address reads whatever bus_rdata returns (0 on the OR-combined bus).

Decomposition:
- Shared package atmega_io_pkg holds:
  - the op encodings (OP_READ=2'b00, OP_WRITE=2'b01, OP_SET=2'b10, OP_CLR=2'b11);
  - the state encoding;
  - RD_WAIT width (4).
- No sub-module. The read-modify logic is a few gates inside the single FSM module.

Test Plan:
- Target atmega_pio with DDR at 0x23 and PORT at 0x20. Write 0x23 <- 0xFF, then write 0x20 <- 0xA5. Required: one bus_wr pulse each; rsp_data = 0xFF, then 0xA5; PIO io_out = 0xA5.
- Read 0x20 after the previous test: bus_rd high exactly 1 cycle; rsp_valid 2 edges after accept; rsp_data = 0xA5.
- PORT=0xA5. Set mask 0x0A, then clear mask 0x81. Required: PORT=0xAF after set, PORT=0x2E after clear; the write in each op follows its read with no idle cycle.
- RD_WAIT=2, read 0x24 with io_in=0x3C: bus_rd high 3 cycles; rsp_data = 0x3C; rsp_valid 4 edges after accept.
- Hold rsp_ready low for 5 cycles with a command pending on cmd_valid: rsp_valid and rsp_data stay stable and cmd_ready stays 0. After the rsp handshake, the pending command is accepted on the next edge.
- Assert rst low during the WRITE cycle of a write 0x20 <- 0x55: all bus outputs 0 immediately. After reset release, cmd_ready=1 and no rsp_valid appears.

Source files
------------

// File: rtl/atmega_io_pkg.sv
// Shared encodings for the ATmega-style IO register bus initiator.
package atmega_io_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_READ  = 2'b00;
    localparam op_t OP_WRITE = 2'b01;
    localparam op_t OP_SET   = 2'b10;
    localparam op_t OP_CLR   = 2'b11;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_READ  = 2'd1;
    localparam logic [STATE_W-1:0] ST_WRITE = 2'd2;
    localparam logic [STATE_W-1:0] ST_RESP  = 2'd3;

    localparam int unsigned RD_WAIT_W = 4;

endpackage

// File: rtl/atmega_io_initiator.sv
// Command-driven master for the IO register bus: read, write, set-bits and
// clear-bits commands become registered bus cycles with one response each.
module atmega_io_initiator
    import atmega_io_pkg::*;
#(
    parameter int unsigned BUS_ADDR_DATA_LEN = 8,
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned RD_WAIT           = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [BUS_ADDR_DATA_LEN-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]        cmd_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         busy,
    output logic [BUS_ADDR_DATA_LEN-1:0] bus_addr,
    output logic                         bus_wr,
    output logic                         bus_rd,
    output logic [DATA_WIDTH-1:0]        bus_wdata,
    input  logic [DATA_WIDTH-1:0]        bus_rdata
);

    localparam logic [RD_WAIT_W-1:0] RD_LAST = RD_WAIT[RD_WAIT_W-1:0];

    logic [STATE_W-1:0]           state, state_d;
    op_t                          op_q, op_d;
    logic [BUS_ADDR_DATA_LEN-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]        mask_q, mask_d;
    logic [RD_WAIT_W-1:0]         cnt, cnt_d;

    logic                         cmd_ready_d;
    logic                         busy_d;
    logic                         rsp_valid_d;
    logic [DATA_WIDTH-1:0]        rsp_data_d;
    logic [BUS_ADDR_DATA_LEN-1:0] bus_addr_d;
    logic                         bus_wr_d;
    logic                         bus_rd_d;
    logic [DATA_WIDTH-1:0]        bus_wdata_d;
    logic [DATA_WIDTH-1:0]        rmw_val;

    // State and every output are plain registers; reset clears the bus at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_READ;
            addr_q    <= '0;
            mask_q    <= '0;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            bus_addr  <= '0;
            bus_wr    <= 1'b0;
            bus_rd    <= 1'b0;
            bus_wdata <= '0;
        end else begin
            state     <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            cnt       <= cnt_d;
            cmd_ready <= cmd_ready_d;
            busy      <= busy_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            bus_addr  <= bus_addr_d;
            bus_wr    <= bus_wr_d;
            bus_rd    <= bus_rd_d;
            bus_wdata <= bus_wdata_d;
        end
    end

    // Next state plus next value of each registered output; bus idles at zero.
    always_comb begin
        state_d     = state;
        op_d        = op_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        cnt_d       = cnt;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;
        bus_addr_d  = '0;
        bus_wr_d    = 1'b0;
        bus_rd_d    = 1'b0;
        bus_wdata_d = '0;
        rmw_val     = (op_q == OP_SET) ? (bus_rdata | mask_q) : (bus_rdata & ~mask_q);

        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d   = cmd_op;
                    addr_d = cmd_addr;
                    mask_d = cmd_data;
                    cnt_d  = '0;
                    bus_addr_d = cmd_addr;
                    if (cmd_op == OP_WRITE) begin
                        state_d     = ST_WRITE;
                        bus_wr_d    = 1'b1;
                        bus_wdata_d = cmd_data;
                    end else begin
                        state_d  = ST_READ;
                        bus_rd_d = 1'b1;
                    end
                end
            end

            ST_READ: begin
                if (cnt == RD_LAST) begin
                    if (op_q == OP_READ) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = bus_rdata;
                    end else begin
                        // Read-modify-write goes straight into the write cycle.
                        state_d     = ST_WRITE;
                        bus_wr_d    = 1'b1;
                        bus_addr_d  = addr_q;
                        bus_wdata_d = rmw_val;
                    end
                end else begin
                    cnt_d      = cnt + RD_WAIT_W'(1);
                    bus_rd_d   = 1'b1;
                    bus_addr_d = addr_q;
                end
            end

            ST_WRITE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = bus_wdata;
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_atmega_io_initiator.sv
// Scoreboard bench: two initiators (RD_WAIT 0 and 2) share an OR-combined bus
// to a small PIO-like register model (PORT 0x20, DDR 0x23, PIN 0x24).
module tb_atmega_io_initiator;
    import atmega_io_pkg::*;

    logic       clk;
    logic       rst;
    logic       prst;
    logic       sel;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_ready;
    logic [7:0] io_in;

    logic       cmd_ready0, cmd_ready2, rsp_valid0, rsp_valid2, busy0, busy2;
    logic [7:0] rsp_data0, rsp_data2;
    logic [7:0] bus_addr0, bus_addr2, bus_wdata0, bus_wdata2;
    logic       bus_wr0, bus_wr2, bus_rd0, bus_rd2;
    logic       cv0, cv2;

    logic       cmd_ready_m, rsp_valid_m, busy_m, bus_wr_m, bus_rd_m;
    logic [7:0] rsp_data_m, bus_addr_m, bus_wdata_m, bus_rdata;
    logic [7:0] port_r, ddr_r, io_out;

    logic [7:0] exp_q[$];
    int checks, errors, mon_checks, mon_errors;
    int rd_total, wr_total, adj_total;
    logic prev_rd;

    assign cv0 = cmd_valid & ~sel;
    assign cv2 = cmd_valid & sel;

    assign cmd_ready_m = sel ? cmd_ready2 : cmd_ready0;
    assign rsp_valid_m = sel ? rsp_valid2 : rsp_valid0;
    assign rsp_data_m  = sel ? rsp_data2  : rsp_data0;
    assign busy_m      = sel ? busy2      : busy0;
    assign bus_addr_m  = bus_addr0 | bus_addr2;
    assign bus_wdata_m = bus_wdata0 | bus_wdata2;
    assign bus_wr_m    = bus_wr0 | bus_wr2;
    assign bus_rd_m    = bus_rd0 | bus_rd2;
    assign io_out      = port_r & ddr_r;

    atmega_io_initiator #(.BUS_ADDR_DATA_LEN(8), .DATA_WIDTH(8), .RD_WAIT(0)) u0 (
        .clk(clk), .rst(rst), .cmd_valid(cv0), .cmd_ready(cmd_ready0), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data0), .busy(busy0), .bus_addr(bus_addr0), .bus_wr(bus_wr0),
        .bus_rd(bus_rd0), .bus_wdata(bus_wdata0), .bus_rdata(bus_rdata)
    );

    atmega_io_initiator #(.BUS_ADDR_DATA_LEN(8), .DATA_WIDTH(8), .RD_WAIT(2)) u2 (
        .clk(clk), .rst(rst), .cmd_valid(cv2), .cmd_ready(cmd_ready2), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data2), .busy(busy2), .bus_addr(bus_addr2), .bus_wr(bus_wr2),
        .bus_rd(bus_rd2), .bus_wdata(bus_wdata2), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral model with its own reset so initiator resets leave it intact.
    always @(posedge clk or negedge prst) begin
        if (!prst) begin
            port_r <= 8'h00;
            ddr_r  <= 8'h00;
        end else if (bus_wr_m) begin
            if (bus_addr_m == 8'h20) port_r <= bus_wdata_m;
            if (bus_addr_m == 8'h23) ddr_r  <= bus_wdata_m;
        end
    end

    always_comb begin
        bus_rdata = 8'h00;
        if (bus_rd_m) begin
            case (bus_addr_m)
                8'h20:   bus_rdata = port_r;
                8'h23:   bus_rdata = ddr_r;
                8'h24:   bus_rdata = io_in;
                default: bus_rdata = 8'h00;
            endcase
        end
    end

    // Monitor: bus legality every cycle, strobe counters, response scoreboard.
    initial begin
        rd_total = 0; wr_total = 0; adj_total = 0; prev_rd = 1'b0;
        mon_checks = 0; mon_errors = 0;
    end

    always @(negedge clk) begin
        if (rst) begin
            mon_checks++;
            if ((bus_wr_m && bus_rd_m) ||
                (!bus_wr_m && !bus_rd_m && (bus_addr_m != 8'h00 || bus_wdata_m != 8'h00))) begin
                mon_errors++;
                $display("FAIL bus_idle wr=%0b rd=%0b addr=%02h wdata=%02h required idle zeros",
                         bus_wr_m, bus_rd_m, bus_addr_m, bus_wdata_m);
            end
            if (bus_rd_m) rd_total++;
            if (bus_wr_m) wr_total++;
            if (bus_wr_m && prev_rd) adj_total++;
            prev_rd = bus_rd_m;
            if (rsp_valid_m && rsp_ready) begin
                mon_checks++;
                if (exp_q.size() == 0) begin
                    mon_errors++;
                    $display("FAIL rsp_unexpected actual %02h required no response", rsp_data_m);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rsp_data_m !== e) begin
                        mon_errors++;
                        $display("FAIL rsp_data actual %02h required %02h", rsp_data_m, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready_m), 1);
    endtask

    // One command with rsp_ready high; checks latency and strobe counts.
    task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] data,
                         input logic [7:0] exp, input int exp_lat, input int exp_rd,
                         input int exp_wr);
        int lat, rd0, wr0, adj0;
        exp_q.push_back(exp);
        wait_ready();
        rd0 = rd_total; wr0 = wr_total; adj0 = adj_total;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 1;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid_m) break;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        @(posedge clk);
        @(negedge clk);
        chk("rd_cycles", 32'(rd_total - rd0), 32'(exp_rd));
        chk("wr_pulses", 32'(wr_total - wr0), 32'(exp_wr));
        chk("rd_wr_adjacent", 32'(adj_total - adj0), (op == OP_SET || op == OP_CLR) ? 1 : 0);
    endtask

    initial begin
        int n;
        checks = 0; errors = 0;
        rst = 1'b0; prst = 1'b0; sel = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 8'h00; cmd_data = 8'h00;
        rsp_ready = 1'b1; io_in = 8'h3C;

        #12;
        chk("rst_bus_addr", 32'(bus_addr_m), 0);
        chk("rst_bus_strobes", 32'({bus_wr_m, bus_rd_m}), 0);
        chk("rst_bus_wdata", 32'(bus_wdata_m), 0);
        chk("rst_rsp", 32'({rsp_valid0, rsp_valid2, rsp_data0, rsp_data2}), 0);
        chk("rst_busy", 32'({busy0, busy2}), 0);
        @(negedge clk);
        rst = 1'b1; prst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'({cmd_ready0, cmd_ready2}), 32'h3);

        issue(OP_WRITE, 8'h23, 8'hFF, 8'hFF, 2, 0, 1);
        issue(OP_WRITE, 8'h20, 8'hA5, 8'hA5, 2, 0, 1);
        chk("io_out", 32'(io_out), 32'hA5);
        issue(OP_READ, 8'h20, 8'h00, 8'hA5, 2, 1, 0);
        issue(OP_SET, 8'h20, 8'h0A, 8'hAF, 3, 1, 1);
        chk("port_after_set", 32'(port_r), 32'hAF);
        issue(OP_CLR, 8'h20, 8'h81, 8'h2E, 3, 1, 1);
        chk("port_after_clr", 32'(port_r), 32'h2E);
        issue(OP_SET, 8'h20, 8'h00, 8'h2E, 3, 1, 1);
        chk("port_mask0", 32'(port_r), 32'h2E);
        issue(OP_READ, 8'h40, 8'h00, 8'h00, 2, 1, 0);

        sel = 1'b1;
        issue(OP_READ, 8'h24, 8'h00, 8'h3C, 4, 3, 0);
        issue(OP_SET, 8'h20, 8'h01, 8'h2F, 5, 3, 1);
        chk("port_wait_set", 32'(port_r), 32'h2F);
        sel = 1'b0;

        // Response back-pressure with the next command already offered.
        wait_ready();
        rsp_ready = 1'b0;
        exp_q.push_back(8'h2F);
        exp_q.push_back(8'hFF);
        cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr = 8'h20; cmd_data = 8'h00;
        @(posedge clk);
        #1 cmd_op = OP_WRITE; cmd_addr = 8'h23; cmd_data = 8'hFF;
        n = 0;
        @(negedge clk);
        while (!rsp_valid_m && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", 32'(rsp_valid_m), 1);
            chk("stall_rsp_data", 32'(rsp_data_m), 32'h2F);
            chk("stall_cmd_ready", 32'(cmd_ready_m), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("pending_ready", 32'(cmd_ready_m), 1);
        @(posedge clk);
        #1;
        chk("pending_accept", 32'({busy_m, cmd_ready_m}), 32'h2);
        cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid_m && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("pending_rsp", 32'(rsp_valid_m), 1);
        @(posedge clk);

        // Reset during the write cycle must abort the write and its response.
        wait_ready();
        cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = 8'h20; cmd_data = 8'h55;
        @(posedge clk);
        #2 rst = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("abort_bus_strobes", 32'({bus_wr_m, bus_rd_m}), 0);
        chk("abort_bus_addr", 32'(bus_addr_m), 0);
        chk("abort_bus_wdata", 32'(bus_wdata_m), 0);
        chk("abort_rsp_valid", 32'(rsp_valid_m), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("abort_port", 32'(port_r), 32'h2F);
        @(negedge clk);
        chk("abort_cmd_ready", 32'(cmd_ready_m), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid_m), 0);
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks + mon_checks, errors + mon_errors);
        $finish;
    end

endmodule
